camera: RTL and testbench

- Pixel-capture front end for an MT9V034-style parallel camera port (10-bit data, LINE_VALID/FRAME_VALID framing).
- Synchronises to frame boundaries and discards any frame already in progress at reset.
- Outputs each accepted pixel, registered, with its line/column coordinates and a one-cycle valid strobe.
- Sits between the sensor pins and downstream frame-buffer/processing logic.

---
 rtl/camera.sv | 89 ++++++++
 tb/tb_camera.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/camera.sv
// camera: MT9V034-style parallel pixel capture with frame sync and line/column tagging
module camera #(
    parameter int LINES = 480,
    parameter int COLUMNS = 752,
    localparam int LW = ($clog2(LINES) > 1) ? $clog2(LINES) : 1,
    localparam int CW = ($clog2(COLUMNS) > 1) ? $clog2(COLUMNS) : 1
) (
    input  logic          PIXCLK,
    input  logic          RESET,
    input  logic          LINE_VALID,
    input  logic          FRAME_VALID,
    input  logic [9:0]    DATA_IN,
    output logic [9:0]    DATA_OUT,
    output logic [LW-1:0] CURRENT_LINE,
    output logic [CW-1:0] CURRENT_COLUMN,
    output logic          PIXEL_VALID
);
    typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

    // Counters carry one extra bit so that "reached LINES/COLUMNS" is representable.
    localparam logic [LW:0] L_MAX = (LW+1)'(LINES);
    localparam logic [CW:0] C_MAX = (CW+1)'(COLUMNS);
    localparam logic [LW:0] L_ONE = (LW+1)'(1);
    localparam logic [CW:0] C_ONE = (CW+1)'(1);

    state_t      r_state;
    logic [LW:0] r_line;
    logic [CW:0] r_col;
    logic        r_ovf;
    logic        r_lv;
    logic        w_accept;
    logic        w_eol;

    // IDLE keeps counters at zero, so one acceptance rule serves both IDLE and FRAME.
    assign w_accept = (r_state != SYNC) && FRAME_VALID && LINE_VALID && !r_ovf &&
                      (r_line < L_MAX) && (r_col < C_MAX);
    assign w_eol    = (r_state == FRAME) && FRAME_VALID && r_lv && !LINE_VALID;

    // Frame-sync state machine, counters and registered pixel outputs.
    always_ff @(posedge PIXCLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= SYNC;
            r_line         <= '0;
            r_col          <= '0;
            r_ovf          <= 1'b0;
            r_lv           <= 1'b0;
            DATA_OUT       <= '0;
            CURRENT_LINE   <= '0;
            CURRENT_COLUMN <= '0;
            PIXEL_VALID    <= 1'b0;
        end else begin
            r_lv        <= LINE_VALID;
            PIXEL_VALID <= w_accept;
            if (w_accept) begin
                DATA_OUT       <= DATA_IN;
                CURRENT_LINE   <= r_line[LW-1:0];
                CURRENT_COLUMN <= r_col[CW-1:0];
            end
            case (r_state)
                SYNC: begin
                    if (!FRAME_VALID) r_state <= IDLE;
                end
                IDLE: begin
                    if (FRAME_VALID) begin
                        r_state <= FRAME;
                        r_col   <= w_accept ? C_ONE : '0;
                    end
                end
                FRAME: begin
                    if (!FRAME_VALID) begin
                        r_state <= IDLE;
                        r_line  <= '0;
                        r_col   <= '0;
                        r_ovf   <= 1'b0;
                    end else if (w_accept) begin
                        r_col <= r_col + C_ONE;
                    end else if (LINE_VALID && r_col == C_MAX) begin
                        r_ovf <= 1'b1;
                    end else if (w_eol) begin
                        r_col  <= '0;
                        r_ovf  <= 1'b0;
                        r_line <= (r_line < L_MAX) ? r_line + L_ONE : r_line;
                    end
                end
                default: r_state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_camera.sv
// tb_camera: scoreboard bench for camera with a 3-line x 2-column frame
module tb_camera;
    logic       PIXCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       LINE_VALID = 1'b0;
    logic       FRAME_VALID = 1'b0;
    logic [9:0] DATA_IN = '0;
    logic [9:0] DATA_OUT;
    logic [1:0] CURRENT_LINE;
    logic [0:0] CURRENT_COLUMN;
    logic       PIXEL_VALID;

    typedef struct {
        logic [9:0] d;
        logic [1:0] l;
        logic [0:0] c;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    camera #(.LINES(3), .COLUMNS(2)) dut (
        .PIXCLK(PIXCLK),
        .RESET(RESET),
        .LINE_VALID(LINE_VALID),
        .FRAME_VALID(FRAME_VALID),
        .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT),
        .CURRENT_LINE(CURRENT_LINE),
        .CURRENT_COLUMN(CURRENT_COLUMN),
        .PIXEL_VALID(PIXEL_VALID)
    );

    always #5 PIXCLK = ~PIXCLK;

    always @(posedge PIXCLK) cyc <= cyc + 1;

    // Scoreboard: every negedge either a due pixel must be present or PIXEL_VALID must be low.
    always @(negedge PIXCLK) begin
        n_vec++;
        if (q.size() != 0 && q[0].due == cyc) begin
            if (PIXEL_VALID !== 1'b1 || DATA_OUT !== q[0].d || CURRENT_LINE !== q[0].l ||
                CURRENT_COLUMN !== q[0].c) begin
                n_err++;
                $display("FAIL pixel cyc=%0d got pv=%b d=%0d l=%0d c=%0d want pv=1 d=%0d l=%0d c=%0d",
                         cyc, PIXEL_VALID, DATA_OUT, CURRENT_LINE, CURRENT_COLUMN,
                         q[0].d, q[0].l, q[0].c);
            end
            void'(q.pop_front());
        end else if (PIXEL_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL no_pixel cyc=%0d got pv=%b d=%0d l=%0d c=%0d want pv=0",
                     cyc, PIXEL_VALID, DATA_OUT, CURRENT_LINE, CURRENT_COLUMN);
        end
    end

    task automatic drive(input logic fv, input logic lv, input int d, input bit acc,
                         input int l, input int c);
        exp_t e;
        @(negedge PIXCLK);
        FRAME_VALID = fv;
        LINE_VALID  = lv;
        DATA_IN     = 10'(d);
        if (acc) begin
            e.d   = 10'(d);
            e.l   = 2'(l);
            e.c   = 1'(c);
            e.due = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        FRAME_VALID = 1'b1;
        LINE_VALID = 1'b1;
        DATA_IN = 10'h3ff;
        repeat (3) @(posedge PIXCLK);
        #2;
        n_vec++;
        if (DATA_OUT !== 10'd0 || CURRENT_LINE !== 2'd0 || CURRENT_COLUMN !== 1'd0 ||
            PIXEL_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values got d=%0d l=%0d c=%0d pv=%b want all 0",
                     DATA_OUT, CURRENT_LINE, CURRENT_COLUMN, PIXEL_VALID);
        end
        @(negedge PIXCLK);
        RESET = 1'b0;
    endtask

    task automatic test_startup_mid_frame;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 100 + i, 1'b0, 0, 0);
        idle(2);
    endtask

    task automatic test_frame_3x2;
        drive(1'b1, 1'b1, 11, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 12, 1'b1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 21, 1'b1, 1, 0);
        drive(1'b1, 1'b1, 22, 1'b1, 1, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 31, 1'b1, 2, 0);
        drive(1'b1, 1'b1, 32, 1'b1, 2, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(2);
    endtask

    task automatic test_overlong_line;
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 41, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 42, 1'b1, 0, 1);
        drive(1'b1, 1'b1, 43, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 51, 1'b1, 1, 0);
        drive(1'b1, 1'b1, 52, 1'b1, 1, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(2);
    endtask

    task automatic test_extra_line;
        for (int l = 0; l < 4; l++) begin
            drive(1'b1, 1'b1, 200 + 10 * l, l < 3, l, 0);
            drive(1'b1, 1'b1, 201 + 10 * l, l < 3, l, 1);
            drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        end
        idle(1);
        drive(1'b1, 1'b1, 300, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 301, 1'b1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(2);
    endtask

    task automatic test_reset_mid_frame;
        drive(1'b1, 1'b1, 400, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 401, 1'b1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 410, 1'b1, 1, 0);
        @(posedge PIXCLK);
        #2;
        RESET = 1'b1;
        q.delete();
        #1;
        n_vec++;
        if (DATA_OUT !== 10'd0 || CURRENT_LINE !== 2'd0 || CURRENT_COLUMN !== 1'd0 ||
            PIXEL_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_frame got d=%0d l=%0d c=%0d pv=%b want all 0",
                     DATA_OUT, CURRENT_LINE, CURRENT_COLUMN, PIXEL_VALID);
        end
        drive(1'b1, 1'b1, 411, 1'b0, 0, 0);
        RESET = 1'b0;
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 420, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 421, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(1);
        drive(1'b1, 1'b1, 500, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 501, 1'b1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 510, 1'b1, 1, 0);
        drive(1'b1, 1'b1, 511, 1'b1, 1, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(2);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 600, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 601, 1'b1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 610, 1'b1, 1, 0);
        drive(1'b0, 1'b1, 611, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 700, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 701, 1'b1, 0, 1);
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 710, 1'b1, 1, 0);
        drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 800, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 900, 1'b1, 0, 0);
        drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
        idle(2);
    endtask

    initial begin
        test_reset;
        test_startup_mid_frame;
        test_frame_3x2;
        test_overlong_line;
        test_extra_line;
        test_reset_mid_frame;
        test_back_to_back;
        idle(2);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending pixels want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
